// File: rtl/mux_arb_nx1.sv
// Registered N:1 arbitrating mux with valid/ready channels.
// Arbitration is round-robin or fixed-priority, with optional packet locking.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_OPEN   | no packet in flight; grant follows the arbitration mode
// ST_LOCKED | a multi-beat packet is in flight; only lock_idx may be granted
module mux_arb_nx1 #(
    parameter int WIDTH    = 8,
    parameter int NUM_IN   = 4,
    parameter int ARB_MODE = 0,
    parameter int PKT_MODE = 0,
    localparam int SRC_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] inp_data,
    input  logic [NUM_IN-1:0]       inp_valid,
    input  logic [NUM_IN-1:0]       inp_last,
    output logic [NUM_IN-1:0]       inp_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [SRC_W-1:0]        out_src,
    input  logic                    out_ready
);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_st_t;

    lock_st_t          lock_st;
    logic [SRC_W-1:0]  lock_idx;
    logic [SRC_W-1:0]  ptr;

    logic              load;
    logic [NUM_IN-1:0] grant;
    logic [SRC_W-1:0]  gidx;
    logic              any_grant;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_last;

    assign load = !out_valid || out_ready;

    always_comb begin
        int idx;
        grant     = '0;
        gidx      = '0;
        any_grant = 1'b0;
        idx       = 0;
        if (PKT_MODE != 0 && lock_st == ST_LOCKED) begin
            if (inp_valid[lock_idx]) begin
                grant[lock_idx] = 1'b1;
                gidx            = lock_idx;
                any_grant       = 1'b1;
            end
        end else if (ARB_MODE != 0) begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (inp_valid[i]) begin
                    grant     = '0;
                    grant[i]  = 1'b1;
                    gidx      = SRC_W'(i);
                    any_grant = 1'b1;
                end
            end
        end else begin
            // Walk from farthest to nearest so the channel right after ptr wins last.
            for (int k = NUM_IN; k >= 1; k--) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_IN) idx = idx - NUM_IN;
                if (inp_valid[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    gidx       = SRC_W'(idx);
                    any_grant  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                sel_data = inp_data[i*WIDTH +: WIDTH];
                sel_last = inp_last[i];
            end
        end
    end

    // Ready is forced low while reset is asserted, even though load is high then.
    assign inp_ready = (rst_n && load) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
            ptr       <= SRC_W'(NUM_IN - 1);
            lock_st   <= ST_OPEN;
            lock_idx  <= '0;
        end else if (load) begin
            if (any_grant) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_src   <= gidx;
                if (ARB_MODE == 0) ptr <= gidx;
                if (PKT_MODE != 0) begin
                    case (lock_st)
                        ST_OPEN: begin
                            if (!sel_last) begin
                                lock_st  <= ST_LOCKED;
                                lock_idx <= gidx;
                            end
                        end
                        ST_LOCKED: begin
                            if (sel_last) lock_st <= ST_OPEN;
                        end
                        default: lock_st <= ST_OPEN;
                    endcase
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Bench for mux_arb_nx1: three instances (round-robin, fixed priority, packet lock)
// driven from shared random and directed stimulus, checked against a beat-level model.
module tb_mux_arb_nx1;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N*W-1:0] inp_data;
    logic [N-1:0]   inp_valid;
    logic [N-1:0]   inp_last;
    logic           out_ready;

    logic [N-1:0] rdy [3];
    logic [W-1:0] od  [3];
    logic         ov  [3];
    logic         ol  [3];
    logic [1:0]   os  [3];

    int amode [3] = '{0, 1, 0};
    int pmode [3] = '{0, 0, 1};

    int total = 0;
    int bad   = 0;

    // model state: what each output register must hold, plus arbitration memory
    bit           m_valid [3];
    logic [W-1:0] m_data  [3];
    bit           m_last  [3];
    int           m_src   [3];
    int           m_ptr   [3];
    bit           m_lock  [3];
    int           m_lch   [3];

    mux_arb_nx1 #(.WIDTH(W), .NUM_IN(N), .ARB_MODE(0), .PKT_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .inp_data(inp_data), .inp_valid(inp_valid),
        .inp_last(inp_last), .inp_ready(rdy[0]), .out_data(od[0]), .out_valid(ov[0]),
        .out_last(ol[0]), .out_src(os[0]), .out_ready(out_ready));

    mux_arb_nx1 #(.WIDTH(W), .NUM_IN(N), .ARB_MODE(1), .PKT_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .inp_data(inp_data), .inp_valid(inp_valid),
        .inp_last(inp_last), .inp_ready(rdy[1]), .out_data(od[1]), .out_valid(ov[1]),
        .out_last(ol[1]), .out_src(os[1]), .out_ready(out_ready));

    mux_arb_nx1 #(.WIDTH(W), .NUM_IN(N), .ARB_MODE(0), .PKT_MODE(1)) u_pk (
        .clk(clk), .rst_n(rst_n), .inp_data(inp_data), .inp_valid(inp_valid),
        .inp_last(inp_last), .inp_ready(rdy[2]), .out_data(od[2]), .out_valid(ov[2]),
        .out_last(ol[2]), .out_src(os[2]), .out_ready(out_ready));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0;
            m_data[k]  = '0;
            m_last[k]  = 0;
            m_src[k]   = 0;
            m_ptr[k]   = N - 1;
            m_lock[k]  = 0;
            m_lch[k]   = 0;
        end
    endtask

    function automatic int pick(input int k);
        int c;
        if (pmode[k] != 0 && m_lock[k]) return inp_valid[m_lch[k]] ? m_lch[k] : -1;
        if (amode[k] != 0) begin
            for (int i = 0; i < N; i++) if (inp_valid[i]) return i;
            return -1;
        end
        for (int s = 1; s <= N; s++) begin
            c = (m_ptr[k] + s) % N;
            if (inp_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic step_model();
        bit ld;
        int g;
        int er;
        for (int k = 0; k < 3; k++) begin
            ld = !m_valid[k] || out_ready;
            g  = ld ? pick(k) : -1;
            er = (g >= 0) ? (1 << g) : 0;
            chk("inp_ready", k, 32'(rdy[k]), 32'(er));
            if (ld) begin
                if (g >= 0) begin
                    m_valid[k] = 1;
                    m_data[k]  = inp_data[g*W +: W];
                    m_last[k]  = inp_last[g];
                    m_src[k]   = g;
                    m_ptr[k]   = g;
                    if (pmode[k] != 0) begin
                        if (!m_lock[k] && !inp_last[g]) begin
                            m_lock[k] = 1;
                            m_lch[k]  = g;
                        end else if (m_lock[k] && inp_last[g]) begin
                            m_lock[k] = 0;
                        end
                    end
                end else begin
                    m_valid[k] = 0;
                end
            end
        end
    endtask

    task automatic check_out();
        for (int k = 0; k < 3; k++) begin
            chk("out_valid", k, 32'(ov[k]), 32'(m_valid[k]));
            chk("out_data",  k, 32'(od[k]), 32'(m_data[k]));
            chk("out_last",  k, 32'(ol[k]), 32'(m_last[k]));
            chk("out_src",   k, 32'(os[k]), 32'(m_src[k]));
        end
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                         input logic [N-1:0] l, input logic r);
        inp_valid = v;
        inp_data  = d;
        inp_last  = l;
        out_ready = r;
        #1;
        step_model();
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic do_reset();
        inp_valid = 4'hF;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, 32'(ov[k]), 32'd0);
            chk("rst_data",  k, 32'(od[k]), 32'd0);
            chk("rst_src",   k, 32'(os[k]), 32'd0);
            chk("rst_ready", k, 32'(rdy[k]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        check_out();
        rst_n = 1'b1;
    endtask

    localparam logic [N*W-1:0] D_SEQ = {8'h13, 8'h12, 8'h11, 8'h10};
    localparam logic [N*W-1:0] D_STL = {8'h13, 8'hA5, 8'h11, 8'h10};
    localparam logic [N*W-1:0] D_IDL = {8'h00, 8'h5A, 8'h00, 8'h00};
    localparam logic [N*W-1:0] D_PKT = {8'h00, 8'h00, 8'hC1, 8'hC0};

    initial begin
        rst_n     = 1'b0;
        inp_valid = '0;
        inp_data  = '0;
        inp_last  = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_out();
        rst_n = 1'b1;

        repeat (1500) begin
            cycle(4'($urandom), $urandom, 4'($urandom), ($urandom_range(3) != 0));
        end

        // asynchronous reset in the middle of random traffic
        do_reset();

        for (int j = 0; j < 5; j++) begin
            cycle(4'hF, D_SEQ, 4'h0, 1'b1);
            chk("rr_src",  0, 32'(os[0]), 32'(j % 4));
            chk("rr_data", 0, 32'(od[0]), 32'(8'h10 + j % 4));
        end

        cycle(4'hF, D_STL, 4'h0, 1'b1);
        chk("pre_stall_src", 0, 32'(os[0]), 32'd1);
        cycle(4'hF, D_STL, 4'h0, 1'b1);
        chk("pre_stall_data", 0, 32'(od[0]), 32'hA5);
        for (int j = 0; j < 3; j++) begin
            cycle(4'hF, D_STL, 4'h0, 1'b0);
            chk("stall_data",  0, 32'(od[0]), 32'hA5);
            chk("stall_src",   0, 32'(os[0]), 32'd2);
            chk("stall_ready", 0, 32'(rdy[0]), 32'd0);
        end
        cycle(4'hF, D_STL, 4'h0, 1'b1);
        chk("post_stall_src", 0, 32'(os[0]), 32'd3);

        for (int j = 0; j < 3; j++) begin
            cycle(4'b1010, D_SEQ, 4'h0, 1'b1);
            chk("fp_src", 1, 32'(os[1]), 32'd1);
        end
        cycle(4'b1000, D_SEQ, 4'h0, 1'b1);
        chk("fp_drop_src", 1, 32'(os[1]), 32'd3);

        cycle(4'b0000, D_IDL, 4'h0, 1'b1);
        chk("idle_valid", 0, 32'(ov[0]), 32'd0);
        cycle(4'b0100, D_IDL, 4'h0, 1'b1);
        chk("single_valid", 0, 32'(ov[0]), 32'd1);
        chk("single_src",   0, 32'(os[0]), 32'd2);
        chk("single_data",  0, 32'(od[0]), 32'h5A);
        cycle(4'b0000, D_IDL, 4'h0, 1'b1);
        chk("single_drop", 0, 32'(ov[0]), 32'd0);
        chk("single_hold", 0, 32'(os[0]), 32'd2);

        do_reset();
        cycle(4'b0011, D_PKT, 4'b0000, 1'b1);
        chk("pkt_b1_src",  2, 32'(os[2]), 32'd0);
        chk("pkt_b1_last", 2, 32'(ol[2]), 32'd0);
        cycle(4'b0011, D_PKT, 4'b0000, 1'b1);
        chk("pkt_b2_src",  2, 32'(os[2]), 32'd0);
        chk("pkt_b2_last", 2, 32'(ol[2]), 32'd0);
        cycle(4'b0011, D_PKT, 4'b0001, 1'b1);
        chk("pkt_b3_src",  2, 32'(os[2]), 32'd0);
        chk("pkt_b3_last", 2, 32'(ol[2]), 32'd1);
        cycle(4'b0011, D_PKT, 4'b0000, 1'b1);
        chk("pkt_next_src", 2, 32'(os[2]), 32'd1);
        chk("pkt_next_data", 2, 32'(od[2]), 32'hC1);

        repeat (300) begin
            cycle(4'($urandom), $urandom, 4'($urandom), ($urandom_range(3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
